// File: rtl/wash_motor_sequencer_pkg.sv
// Shared definitions for the wash-phase drum motor sequencer.
// State encodings are 3-bit; default segment lengths are in ticks, where
// one tick is the 1 s timebase pulse supplied by the washer controller.
package wash_motor_sequencer_pkg;

    localparam int RUN_T_DEF   = 4;
    localparam int PAUSE_T_DEF = 2;
    localparam int CYC_W_DEF   = 6;
    localparam int TIME_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_P1    = 3'd2,
        ST_REV   = 3'd3,
        ST_P2    = 3'd4,
        ST_DONE  = 3'd5,
        ST_ESTOP = 3'd6
    } state_t;

    // A sequence counts as busy from acceptance up to and including DONE.
    function automatic logic busy_state(input state_t s);
        case (s)
            ST_FWD, ST_P1, ST_REV, ST_P2, ST_DONE: busy_state = 1'b1;
            default:                               busy_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wash_motor_sequencer_seg_timer.sv
// Segment timer: loadable down-counter advanced by the tick pulse.
// Load has priority over tick, so a tick on the load clock is not counted.
// expired flags the tick that arrives while the count is already zero.
module wash_motor_sequencer_seg_timer #(
    parameter int TIME_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [TIME_W-1:0] i_load_val,
    input  logic              i_tick,
    output logic              o_expired
);

    localparam logic [TIME_W-1:0] T_ONE = TIME_W'(1'b1);

    logic [TIME_W-1:0] r_count;

    // Count register: reload on segment entry, otherwise decrement per tick down to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - T_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = i_tick && (r_count == '0);

endmodule

// File: rtl/wash_motor_sequencer.sv
// Wash-phase drum motor sequencer: forward run, pause, reverse run, pause,
// repeated for the requested number of cycles. Emergency forces the motor
// off and latches alarm until it is released. Both directions are never
// driven together and are always separated by a pause segment.
// Optional build macro WASH_SOFTSTART_EN: forward drive pulses on/off per
// tick during the first forward segment of each sequence.
module wash_motor_sequencer
    import wash_motor_sequencer_pkg::*;
#(
    parameter int RUN_T   = RUN_T_DEF,
    parameter int PAUSE_T = PAUSE_T_DEF,
    parameter int CYC_W   = CYC_W_DEF,
    parameter int TIME_W  = TIME_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic [CYC_W-1:0] cycles,
    input  logic             emergency,
    output logic             zheng,
    output logic             fan,
    output logic             busy,
    output logic             done,
    output logic             alarm,
    output logic [CYC_W-1:0] cyc_left
);

    localparam logic [TIME_W-1:0] RUN_LOAD   = TIME_W'(RUN_T - 1);
    localparam logic [TIME_W-1:0] PAUSE_LOAD = TIME_W'(PAUSE_T - 1);
    localparam logic [CYC_W-1:0]  CYC_ONE    = CYC_W'(1'b1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CYC_W-1:0]  r_cyc_left;
    logic [CYC_W-1:0]  w_cyc_nxt;
    logic              w_load;
    logic [TIME_W-1:0] w_load_val;
    logic              w_expired;

    logic r_zheng, r_fan, r_busy, r_done, r_alarm;
    logic w_zheng_nxt, w_fan_nxt, w_busy_nxt, w_done_nxt, w_alarm_nxt;

    wash_motor_sequencer_seg_timer #(
        .TIME_W (TIME_W)
    ) u_seg_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_tick     (tick),
        .o_expired  (w_expired)
    );

    // Next-state, timer reload and cycle-count decisions; emergency overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc_left;
        w_load      = 1'b0;
        w_load_val  = RUN_LOAD;
        if (emergency) begin
            w_state_nxt = ST_ESTOP;
            w_cyc_nxt   = '0;
            w_load      = 1'b1;
            w_load_val  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_cyc_nxt = cycles;
                        if (cycles == '0) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_FWD;
                            w_load      = 1'b1;
                            w_load_val  = RUN_LOAD;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FWD: begin
                    if (w_expired) begin
                        w_state_nxt = ST_P1;
                        w_load      = 1'b1;
                        w_load_val  = PAUSE_LOAD;
                    end else begin
                        w_state_nxt = ST_FWD;
                    end
                end
                ST_P1: begin
                    if (w_expired) begin
                        w_state_nxt = ST_REV;
                        w_load      = 1'b1;
                        w_load_val  = RUN_LOAD;
                    end else begin
                        w_state_nxt = ST_P1;
                    end
                end
                ST_REV: begin
                    if (w_expired) begin
                        w_state_nxt = ST_P2;
                        w_load      = 1'b1;
                        w_load_val  = PAUSE_LOAD;
                    end else begin
                        w_state_nxt = ST_REV;
                    end
                end
                ST_P2: begin
                    if (w_expired) begin
                        w_cyc_nxt = r_cyc_left - CYC_ONE;
                        if (r_cyc_left == CYC_ONE) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_FWD;
                            w_load      = 1'b1;
                            w_load_val  = RUN_LOAD;
                        end
                    end else begin
                        w_state_nxt = ST_P2;
                    end
                end
                ST_DONE:  w_state_nxt = ST_IDLE;
                ST_ESTOP: w_state_nxt = ST_IDLE;
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cyc_nxt   = '0;
                end
            endcase
        end
    end

`ifdef WASH_SOFTSTART_EN
    logic r_first_fwd, r_soft_on;
    logic w_first_nxt, w_soft_nxt;

    // Soft-start tracking: first forward segment of a sequence toggles drive per tick.
    always_comb begin
        w_first_nxt = r_first_fwd;
        w_soft_nxt  = r_soft_on;
        if (w_state_nxt != ST_FWD) begin
            w_first_nxt = 1'b0;
            w_soft_nxt  = 1'b1;
        end else if (r_state != ST_FWD) begin
            w_first_nxt = (r_state == ST_IDLE);
            w_soft_nxt  = 1'b1;
        end else if (tick) begin
            w_soft_nxt  = ~r_soft_on;
        end else begin
            w_soft_nxt  = r_soft_on;
        end
        w_zheng_nxt = (w_state_nxt == ST_FWD) && (!w_first_nxt || w_soft_nxt);
    end

    // Soft-start registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_first_fwd <= 1'b0;
            r_soft_on   <= 1'b1;
        end else begin
            r_first_fwd <= w_first_nxt;
            r_soft_on   <= w_soft_nxt;
        end
    end
`else
    // Forward drive is steady for the whole forward segment.
    always_comb begin
        w_zheng_nxt = (w_state_nxt == ST_FWD);
    end
`endif

    // Output decode from the upcoming state; done fires on the DONE->IDLE step.
    always_comb begin
        w_fan_nxt   = (w_state_nxt == ST_REV);
        w_busy_nxt  = busy_state(w_state_nxt);
        w_done_nxt  = (r_state == ST_DONE) && (w_state_nxt == ST_IDLE);
        w_alarm_nxt = (w_state_nxt == ST_ESTOP);
    end

    // State, cycle counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cyc_left <= '0;
            r_zheng    <= 1'b0;
            r_fan      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc_left <= w_cyc_nxt;
            r_zheng    <= w_zheng_nxt;
            r_fan      <= w_fan_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_alarm    <= w_alarm_nxt;
        end
    end

    assign zheng    = r_zheng;
    assign fan      = r_fan;
    assign busy     = r_busy;
    assign done     = r_done;
    assign alarm    = r_alarm;
    assign cyc_left = r_cyc_left;

endmodule

// File: tb/tb_wash_motor_sequencer.sv
// Bench for wash_motor_sequencer: a per-clock behavioural model pushes the
// expected outputs into a scoreboard queue as each input set is driven; a
// monitor pops and compares after every clock edge, and also watches the
// direction-separation rule. Scenario table rows carry expected totals.
module tb_wash_motor_sequencer;

    localparam int RUN_T   = 4;
    localparam int PAUSE_T = 2;
    localparam int CYC_W   = 6;
    localparam int TIME_W  = 4;
    localparam int TICK_P  = 10;

    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_DONEP = 2;
    localparam int MD_ESTOP = 3;

    logic             clk;
    logic             rst;
    logic             tick;
    logic             start;
    logic [CYC_W-1:0] cycles;
    logic             emergency;
    logic             zheng, fan, busy, done, alarm;
    logic [CYC_W-1:0] cyc_left;

    typedef struct {
        logic             z;
        logic             f;
        logic             b;
        logic             d;
        logic             a;
        logic [CYC_W-1:0] cl;
    } exp_t;

    typedef struct {
        int cyc0;
        int cyc2;
        int emerg_at;
        int emerg_len;
        int restart_at;
        int rst_at;
        int tick_ofs;
        int len;
        int exp_done;
        int exp_zent;
        int exp_fent;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int               m_mode = MD_IDLE;
    int               m_seg  = 0;
    int               m_rem  = 0;
    logic [CYC_W-1:0] m_cyc  = '0;
    logic             m_done = 1'b0;
    logic             m_first = 1'b0;
    logic             m_phase = 1'b1;

    int   done_total = 0;
    int   zent_total = 0;
    int   fent_total = 0;
    int   last_dir   = 0;
    int   low_ticks  = 0;
    logic prev_z     = 1'b0;
    logic prev_f     = 1'b0;

    wash_motor_sequencer #(
        .RUN_T   (RUN_T),
        .PAUSE_T (PAUSE_T),
        .CYC_W   (CYC_W),
        .TIME_W  (TIME_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .cycles    (cycles),
        .emergency (emergency),
        .zheng     (zheng),
        .fan       (fan),
        .busy      (busy),
        .done      (done),
        .alarm     (alarm),
        .cyc_left  (cyc_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: segment index 0..3 with ticks-remaining countdown.
    task automatic model_step(input logic r, input logic s, input logic [CYC_W-1:0] c,
                              input logic e, input logic t);
        m_done = 1'b0;
        if (!r) begin
            m_mode = MD_IDLE;
            m_cyc  = '0;
        end else if (e) begin
            m_mode = MD_ESTOP;
            m_cyc  = '0;
        end else begin
            case (m_mode)
                MD_IDLE: begin
                    if (s) begin
                        m_cyc = c;
                        if (c == '0) begin
                            m_mode = MD_DONEP;
                        end else begin
                            m_mode  = MD_RUN;
                            m_seg   = 0;
                            m_rem   = RUN_T;
                            m_first = 1'b1;
                            m_phase = 1'b1;
                        end
                    end
                end
                MD_DONEP: begin
                    m_mode = MD_IDLE;
                    m_done = 1'b1;
                end
                MD_ESTOP: m_mode = MD_IDLE;
                MD_RUN: begin
                    if (t) begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin
                            m_seg   = m_seg + 1;
                            m_phase = 1'b1;
                            if (m_seg == 1) m_first = 1'b0;
                            if (m_seg == 4) begin
                                m_seg = 0;
                                m_cyc = m_cyc - 6'd1;
                                if (m_cyc == '0) m_mode = MD_DONEP;
                            end
                            m_rem = ((m_seg % 2) == 0) ? RUN_T : PAUSE_T;
                        end else if (m_seg == 0) begin
                            m_phase = ~m_phase;
                        end
                    end
                end
                default: m_mode = MD_IDLE;
            endcase
        end
    endtask

    // Drive one clock of inputs and push the model's expected outputs.
    task automatic drive_one(input logic r, input logic s, input logic [CYC_W-1:0] c,
                             input logic e, input logic t);
        exp_t x;
        @(negedge clk);
        rst = r; start = s; cycles = c; emergency = e; tick = t;
        model_step(r, s, c, e, t);
`ifdef WASH_SOFTSTART_EN
        x.z = (m_mode == MD_RUN) && (m_seg == 0) && (!m_first || m_phase);
`else
        x.z = (m_mode == MD_RUN) && (m_seg == 0);
`endif
        x.f  = (m_mode == MD_RUN) && (m_seg == 2);
        x.b  = (m_mode == MD_RUN) || (m_mode == MD_DONEP);
        x.d  = m_done;
        x.a  = (m_mode == MD_ESTOP);
        x.cl = m_cyc;
        sb_q.push_back(x);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare plus direction-separation watch.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({zheng, fan, busy, done, alarm, cyc_left} !== {e.z, e.f, e.b, e.d, e.a, e.cl}) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got z=%b f=%b b=%b d=%b a=%b cl=%0d expected z=%b f=%b b=%b d=%b a=%b cl=%0d",
                         $time, zheng, fan, busy, done, alarm, cyc_left, e.z, e.f, e.b, e.d, e.a, e.cl);
            end
            n_checks++;
            if (zheng && fan) begin
                n_fail++;
                $display("FAIL overlap t=%0t: got zheng=1 fan=1 expected not both", $time);
            end
            if (tick && !prev_z && !prev_f) low_ticks++;
            if (done) done_total++;
            if (!busy) begin
                last_dir  = 0;
                low_ticks = 0;
            end else if (zheng || fan) begin
                if ((zheng && !prev_z && last_dir == 2) || (fan && !prev_f && last_dir == 1)) begin
                    n_checks++;
                    if (low_ticks < PAUSE_T) begin
                        n_fail++;
                        $display("FAIL pause t=%0t: got %0d idle ticks expected >= %0d",
                                 $time, low_ticks, PAUSE_T);
                    end
                end
                if (zheng && last_dir != 1) zent_total++;
                if (fan && last_dir != 2) fent_total++;
                last_dir  = zheng ? 1 : 2;
                low_ticks = 0;
            end
            prev_z = zheng;
            prev_f = fan;
        end
    end

    initial begin
        vec_t vecs[7];
        int   d0, z0, f0;
        logic s, e, rr, t;
        logic [CYC_W-1:0] c;

        //           cyc0 cyc2 em_at em_len rs_at rst_at tofs len done zent fent
        vecs[0] = '{2,  0,  -1,  0,  -1,  -1,  5, 260, 1, 2, 2};
        vecs[1] = '{0,  0,  -1,  0,  -1,  -1,  5,  20, 1, 0, 0};
        vecs[2] = '{1,  0,  70, 20,  -1,  -1,  5, 130, 0, 1, 1};
        vecs[3] = '{1,  5,  -1,  0,  20,  -1,  5, 140, 1, 1, 1};
        vecs[4] = '{1,  1,  -1,  0,  40,  20,  5, 180, 1, 2, 1};
        vecs[5] = '{3,  0,   0,  3,  -1,  -1,  5,  30, 0, 0, 0};
        vecs[6] = '{1,  0,  -1,  0,  -1,  -1,  0, 150, 1, 1, 1};

        rst = 1'b0; start = 1'b0; cycles = '0; emergency = 1'b0; tick = 1'b0;

        // Reset state.
        for (int i = 0; i < 3; i++) drive_one(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        drive_one(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);

        // Hand sequence: zero-cycle start, start during DONE ignored, then accepted again.
        d0 = done_total;
        drive_one(1'b1, 1'b1, 6'd0, 1'b0, 1'b0);
        drive_one(1'b1, 1'b1, 6'd3, 1'b0, 1'b0);
        drive_one(1'b1, 1'b1, 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_one(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check_int("zero-cycle done pulses", done_total - d0, 2);

        // Scenario table.
        for (int k = 0; k < 7; k++) begin
            d0 = done_total; z0 = zent_total; f0 = fent_total;
            for (int r = 0; r < vecs[k].len; r++) begin
                s  = (r == 0) || (r == vecs[k].restart_at);
                c  = (r == 0) ? CYC_W'(vecs[k].cyc0) : CYC_W'(vecs[k].cyc2);
                e  = (vecs[k].emerg_at >= 0) && (r >= vecs[k].emerg_at) &&
                     (r < vecs[k].emerg_at + vecs[k].emerg_len);
                rr = (r != vecs[k].rst_at);
                t  = ((r % TICK_P) == vecs[k].tick_ofs);
                drive_one(rr, s, c, e, t);
            end
            @(posedge clk); #2;
            check_int($sformatf("vec%0d done pulses", k), done_total - d0, vecs[k].exp_done);
            check_int($sformatf("vec%0d fwd entries", k), zent_total - z0, vecs[k].exp_zent);
            check_int($sformatf("vec%0d rev entries", k), fent_total - f0, vecs[k].exp_fent);
        end

        check_int("scoreboard drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
